// File: rtl/pe_tree_acc.sv
// pe_tree_acc: float16 FxF window dot product (multiplier bank + padded adder tree) with CH-channel accumulation.
// Optional build macro PE_TREE_RELU_EN clamps results with sign bit set to +0.0.

package pe_tree_acc_pkg;

  // float16 multiply, round-to-nearest-even; subnormals flush to zero, overflow saturates to Inf
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic               s;
    logic [21:0]        p;
    logic [9:0]         m;
    logic               g;
    logic               st;
    logic [10:0]        mr;
    logic signed [7:0]  e;
    logic [15:0]        res;
    s = a[15] ^ b[15];
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
    if (p[21]) begin
      m  = p[20:11];
      g  = p[10];
      st = |p[9:0];
      e  = e + 8'sd1;
    end else begin
      m  = p[19:10];
      g  = p[9];
      st = |p[8:0];
    end
    mr = {1'b0, m} + {10'd0, g & (st | m[0])};
    if (mr[10]) begin
      e = e + 8'sd1;
    end else begin
      e = e;
    end
    if ((a[14:10] == 5'd0) || (b[14:10] == 5'd0)) begin
      res = {s, 15'd0};
    end else if ((a[14:10] == 5'h1f) || (b[14:10] == 5'h1f) || (e >= 8'sd31)) begin
      res = {s, 5'h1f, 10'd0};
    end else if (e <= 8'sd0) begin
      res = {s, 15'd0};
    end else begin
      res = {s, e[4:0], mr[9:0]};
    end
    return res;
  endfunction

  // float16 add with guard/round/sticky bits; exact cancellation yields +0.0
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]        x;
    logic [15:0]        y;
    logic [15:0]        mx;
    logic [15:0]        my;
    logic [15:0]        sum;
    logic [15:0]        n;
    logic [47:0]        sh;
    logic [4:0]         d;
    logic [3:0]         sft;
    logic [10:0]        mr;
    logic signed [7:0]  e;
    logic [15:0]        res;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d   = x[14:10] - y[14:10];
    mx  = {3'b001, x[9:0], 3'b000};
    sh  = {3'b001, y[9:0], 3'b000, 32'd0} >> d;
    my  = sh[47:32] | {15'd0, |sh[31:0]};
    sum = (x[15] ^ y[15]) ? (mx - my) : (mx + my);
    e   = $signed({3'b000, x[14:10]});
    sft = 4'd0;
    if (sum[14]) begin
      n = {1'b0, sum[15:1]} | {15'd0, sum[0]};
      e = e + 8'sd1;
    end else begin
      for (int i = 0; i < 14; i++) begin
        if (sum[i]) sft = 4'(13 - i);
      end
      n = sum << sft;
      e = e - $signed({4'd0, sft});
    end
    mr = {1'b0, n[12:3]} + {10'd0, n[2] & (n[1] | n[0] | n[3])};
    if (mr[10]) begin
      e = e + 8'sd1;
    end else begin
      e = e;
    end
    if (y[14:10] == 5'd0) begin
      res = (x[14:10] == 5'd0) ? {a[15] & b[15], 15'd0} : x;
    end else if (x[14:10] == 5'h1f) begin
      res = x;
    end else if (sum == 16'd0) begin
      res = 16'h0000;
    end else if (e >= 8'sd31) begin
      res = {x[15], 5'h1f, 10'd0};
    end else if (e <= 8'sd0) begin
      res = {x[15], 15'd0};
    end else begin
      res = {x[15], e[4:0], mr[9:0]};
    end
    return res;
  endfunction

endpackage

module pe_fp16_pipe #(
  parameter int LAT    = 1,
  parameter bit IS_MUL = 1'b0
) (
  input  logic        clk,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  import pe_tree_acc_pkg::*;

  logic [15:0] res_s;
  logic [15:0] sh_r [LAT];

  // select the arithmetic core for this stage
  always_comb begin
    res_s = 16'h0000;
    if (IS_MUL) begin
      res_s = fp16_mul(a, b);
    end else begin
      res_s = fp16_add(a, b);
    end
  end

  // data-only delay line; validity is tracked by the owner
  always_ff @(posedge clk) begin
    sh_r[0] <= res_s;
    for (int i = 1; i < LAT; i++) sh_r[i] <= sh_r[i-1];
  end

  assign y = sh_r[LAT-1];
endmodule

module pe_tree_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int F          = 3,
  parameter int CH         = 4,
  parameter int MULT_LAT   = 1,
  parameter int ADD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH*F*F-1:0] oData,
  input  logic [DATA_WIDTH*F*F-1:0] param,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     result
);
  localparam int NP = F * F;
  localparam int L  = $clog2(NP);
  localparam int N  = 1 << L;
  localparam int T  = MULT_LAT + L * ADD_LAT;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int GW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  logic              accept_s;
  logic              ready_r;
  logic [GW-1:0]     gap_r;
  logic [CW-1:0]     chan_in_r;
  logic [T-1:0]      vld_r;
  logic [CW-1:0]     chan_sr_r [T];
  logic [ADD_LAT-1:0] avld_r;
  logic [CW-1:0]     achan_r [ADD_LAT];
  logic [15:0]       node_s [2*N-1];
  logic [15:0]       acc_b_s;
  logic [15:0]       acc_sum_s;
  logic [15:0]       acc_r;
  logic [15:0]       res_next_s;
  logic [15:0]       result_r;
  logic              out_valid_r;

  assign accept_s  = in_valid & ready_r;
  assign in_ready  = ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;

  // heap-ordered tree: leaves at N-1..2N-2, node k sums children 2k+1 and 2k+2, root at 0
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_leaf
      if (gi < NP) begin : g_mul
        pe_fp16_pipe #(.LAT(MULT_LAT), .IS_MUL(1'b1)) u_mul (
          .clk (clk),
          .a   (oData[gi*DATA_WIDTH +: 16]),
          .b   (param[gi*DATA_WIDTH +: 16]),
          .y   (node_s[N-1+gi])
        );
      end else begin : g_pad
        assign node_s[N-1+gi] = 16'h0000;
      end
    end
    for (gi = 0; gi < N - 1; gi++) begin : g_add
      pe_fp16_pipe #(.LAT(ADD_LAT), .IS_MUL(1'b0)) u_add (
        .clk (clk),
        .a   (node_s[2*gi+1]),
        .b   (node_s[2*gi+2]),
        .y   (node_s[gi])
      );
    end
  endgenerate

  // channel 0 starts a fresh sum; a sum landing this cycle is forwarded ahead of acc_r
  always_comb begin
    acc_b_s = 16'h0000;
    if (chan_sr_r[T-1] == {CW{1'b0}}) begin
      acc_b_s = 16'h0000;
    end else if (avld_r[ADD_LAT-1]) begin
      acc_b_s = acc_sum_s;
    end else begin
      acc_b_s = acc_r;
    end
  end

  pe_fp16_pipe #(.LAT(ADD_LAT), .IS_MUL(1'b0)) u_acc (
    .clk (clk),
    .a   (node_s[0]),
    .b   (acc_b_s),
    .y   (acc_sum_s)
  );

  // optional clamp of negative (including -0.0) results
  always_comb begin
    res_next_s = acc_sum_s;
`ifdef PE_TREE_RELU_EN
    if (acc_sum_s[15]) begin
      res_next_s = 16'h0000;
    end else begin
      res_next_s = acc_sum_s;
    end
`else
    res_next_s = acc_sum_s;
`endif
  end

  // issue spacing, channel count, valid/tag pipelines, accumulator and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_r     <= 1'b1;
      gap_r       <= {GW{1'b0}};
      chan_in_r   <= {CW{1'b0}};
      vld_r       <= {T{1'b0}};
      avld_r      <= {ADD_LAT{1'b0}};
      for (int i = 0; i < T; i++) chan_sr_r[i] <= {CW{1'b0}};
      for (int i = 0; i < ADD_LAT; i++) achan_r[i] <= {CW{1'b0}};
      acc_r       <= 16'h0000;
      result_r    <= 16'h0000;
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        gap_r     <= GW'(ADD_LAT - 1);
        ready_r   <= (ADD_LAT == 1);
        chan_in_r <= (chan_in_r == CW'(CH - 1)) ? {CW{1'b0}} : chan_in_r + CW'(1);
      end else if (gap_r != {GW{1'b0}}) begin
        gap_r   <= gap_r - GW'(1);
        ready_r <= (gap_r == GW'(1));
      end else begin
        ready_r <= 1'b1;
      end
      vld_r[0]     <= accept_s;
      chan_sr_r[0] <= chan_in_r;
      for (int i = 1; i < T; i++) begin
        vld_r[i]     <= vld_r[i-1];
        chan_sr_r[i] <= chan_sr_r[i-1];
      end
      avld_r[0]  <= vld_r[T-1];
      achan_r[0] <= chan_sr_r[T-1];
      for (int i = 1; i < ADD_LAT; i++) begin
        avld_r[i]  <= avld_r[i-1];
        achan_r[i] <= achan_r[i-1];
      end
      if (avld_r[ADD_LAT-1]) begin
        acc_r <= acc_sum_s;
        if (achan_r[ADD_LAT-1] == CW'(CH - 1)) begin
          result_r    <= res_next_s;
          out_valid_r <= 1'b1;
        end else begin
          out_valid_r <= 1'b0;
        end
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule
